// File: rtl/ea_sequencer.sv
// PDP-8 effective-address sequencer: resolves direct, indirect and auto-index
// operand addresses, running the pointer read and read-increment-write cycles.
module ea_sequencer (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [6:0]  IR,
    input  logic [11:0] PCLATCHED,
    input  logic        DIR,
    input  logic        IND,
    input  logic        PPIND,
    input  logic        MP,
    output logic [11:0] MEM_ADDR,
    output logic        MEM_RD,
    output logic        MEM_WR,
    output logic [11:0] MEM_WDATA,
    input  logic [11:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic [11:0] EA,
    output logic        EA_VALID,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEFER_RD = 2'd1,
        AUTO_WR  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        auto_inc, auto_inc_nxt;
    logic [11:0] ea_nxt, addr_nxt, wdata_nxt;
    logic        rd_nxt, wr_nxt;
    logic [11:0] pa;

    assign pa = MP ? {PCLATCHED[11:7], IR} : {5'b0, IR};

    always_comb begin
        state_nxt    = state;
        auto_inc_nxt = auto_inc;
        ea_nxt       = EA;
        addr_nxt     = MEM_ADDR;
        wdata_nxt    = MEM_WDATA;
        rd_nxt       = MEM_RD;
        wr_nxt       = MEM_WR;
        unique case (state)
            IDLE: begin
                if (START) begin
                    if (PPIND || IND) begin
                        addr_nxt     = pa;
                        rd_nxt       = 1'b1;
                        auto_inc_nxt = PPIND;
                        state_nxt    = DEFER_RD;
                    end else if (DIR) begin
                        ea_nxt    = pa;
                        state_nxt = DONE;
                    end
                end
            end
            DEFER_RD: begin
                if (MEM_ACK) begin
                    rd_nxt = 1'b0;
                    if (auto_inc) begin
                        // Incremented pointer lives in MEM_WDATA until the write completes
                        wr_nxt    = 1'b1;
                        wdata_nxt = MEM_RDATA + 12'd1;
                        state_nxt = AUTO_WR;
                    end else begin
                        ea_nxt    = MEM_RDATA;
                        state_nxt = DONE;
                    end
                end
            end
            AUTO_WR: begin
                if (MEM_ACK) begin
                    wr_nxt    = 1'b0;
                    ea_nxt    = MEM_WDATA;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                auto_inc_nxt = 1'b0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            auto_inc  <= 1'b0;
            EA        <= '0;
            EA_VALID  <= 1'b0;
            BUSY      <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_RD    <= 1'b0;
            MEM_WR    <= 1'b0;
        end else begin
            state     <= state_nxt;
            auto_inc  <= auto_inc_nxt;
            EA        <= ea_nxt;
            EA_VALID  <= (state_nxt == DONE);
            BUSY      <= (state_nxt != IDLE);
            MEM_ADDR  <= addr_nxt;
            MEM_WDATA <= wdata_nxt;
            MEM_RD    <= rd_nxt;
            MEM_WR    <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_ea_sequencer.sv
// Directed, table-driven bench for ea_sequencer with hand-written corner sequences.
module tb_ea_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [6:0]  IR;
    logic [11:0] PCLATCHED;
    logic        DIR, IND, PPIND, MP;
    logic [11:0] MEM_ADDR, MEM_WDATA, MEM_RDATA, EA;
    logic        MEM_RD, MEM_WR, MEM_ACK, EA_VALID, BUSY;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    logic [11:0] last_ea = '0;

    ea_sequencer dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .IR(IR), .PCLATCHED(PCLATCHED),
        .DIR(DIR), .IND(IND), .PPIND(PPIND), .MP(MP),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
        .EA(EA), .EA_VALID(EA_VALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        dir, ind, ppind, mp;
        logic [11:0] pc;
        logic [6:0]  ir;
        logic [11:0] rdata;
        int unsigned waits;
        logic [11:0] exp_addr, exp_wdata, exp_ea;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic dir, input logic ind, input logic ppind,
                                input logic mp, input logic [11:0] pc, input logic [6:0] ir,
                                input logic [11:0] rdata, input int unsigned waits,
                                input logic [11:0] exp_addr, input logic [11:0] exp_wdata,
                                input logic [11:0] exp_ea);
        vec_t v;
        v.dir = dir; v.ind = ind; v.ppind = ppind; v.mp = mp;
        v.pc = pc; v.ir = ir; v.rdata = rdata; v.waits = waits;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_ea = exp_ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %o expected %o (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        START = 0; DIR = 0; IND = 0; PPIND = 0; MEM_ACK = 0;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    task automatic run(input vec_t v);
        logic indirect, any_mode;
        indirect = v.ind | v.ppind;
        any_mode = indirect | v.dir;
        DIR = v.dir; IND = v.ind; PPIND = v.ppind; MP = v.mp;
        PCLATCHED = v.pc; IR = v.ir; START = 1;
        @(negedge CLK);
        START = 0; DIR = 0; IND = 0; PPIND = 0;
        IR = ~v.ir; PCLATCHED = ~v.pc; MP = ~v.mp;
        if (!any_mode) begin
            for (int i = 0; i < 3; i++) begin
                chk("nomode_busy", {11'b0, BUSY}, 12'd0);
                chk("nomode_valid", {11'b0, EA_VALID}, 12'd0);
                chk("nomode_rdwr", {10'b0, MEM_RD, MEM_WR}, 12'd0);
                MEM_ACK = (i == 1);
                @(negedge CLK);
                MEM_ACK = 0;
            end
            chk("nomode_ea_hold", EA, last_ea);
            return;
        end
        if (indirect) begin
            for (int unsigned w = 0; w <= v.waits; w++) begin
                chk("rd_req", {10'b0, MEM_RD, MEM_WR}, 12'd2);
                chk("rd_addr", MEM_ADDR, v.exp_addr);
                chk("rd_busy", {11'b0, BUSY}, 12'd1);
                chk("rd_novalid", {11'b0, EA_VALID}, 12'd0);
                if (w == v.waits) begin MEM_ACK = 1; MEM_RDATA = v.rdata; end
                @(negedge CLK);
            end
            MEM_ACK = 0; MEM_RDATA = 12'o6666;
            if (v.ppind) begin
                for (int unsigned w = 0; w <= v.waits; w++) begin
                    chk("wr_req", {10'b0, MEM_RD, MEM_WR}, 12'd1);
                    chk("wr_addr", MEM_ADDR, v.exp_addr);
                    chk("wr_data", MEM_WDATA, v.exp_wdata);
                    chk("wr_novalid", {11'b0, EA_VALID}, 12'd0);
                    if (w == v.waits) MEM_ACK = 1;
                    @(negedge CLK);
                end
                MEM_ACK = 0;
            end
        end
        chk("done_valid", {11'b0, EA_VALID}, 12'd1);
        chk("done_ea", EA, v.exp_ea);
        chk("done_rdwr", {10'b0, MEM_RD, MEM_WR}, 12'd0);
        chk("done_busy", {11'b0, BUSY}, 12'd1);
        last_ea = v.exp_ea;
        @(negedge CLK);
        chk("idle_valid", {11'b0, EA_VALID}, 12'd0);
        chk("idle_busy", {11'b0, BUSY}, 12'd0);
        chk("idle_ea_hold", EA, last_ea);
    endtask

    initial begin
        //               dir ind pp mp  pc        ir      rdata    w  addr      wdata     ea
        tbl[0] = mk(1, 0, 0, 0, 12'o4200, 7'o123, 12'o0000, 0, 12'o0000, 12'o0000, 12'o0123);
        tbl[1] = mk(1, 0, 0, 1, 12'o4200, 7'o045, 12'o0000, 0, 12'o0000, 12'o0000, 12'o4245);
        tbl[2] = mk(0, 1, 0, 1, 12'o1000, 7'o010, 12'o2345, 2, 12'o1010, 12'o0000, 12'o2345);
        tbl[3] = mk(0, 0, 1, 0, 12'o4200, 7'o017, 12'o7777, 0, 12'o0017, 12'o0000, 12'o0000);
        tbl[4] = mk(0, 0, 1, 0, 12'o0000, 7'o012, 12'o0377, 1, 12'o0012, 12'o0400, 12'o0400);
        tbl[5] = mk(1, 1, 1, 0, 12'o3000, 7'o013, 12'o1234, 0, 12'o0013, 12'o1235, 12'o1235);
        tbl[6] = mk(1, 1, 0, 0, 12'o3000, 7'o077, 12'o0000, 1, 12'o0077, 12'o0000, 12'o0000);
        tbl[7] = mk(0, 1, 0, 1, 12'o7777, 7'o177, 12'o5555, 0, 12'o7777, 12'o0000, 12'o5555);
        tbl[8] = mk(0, 0, 0, 1, 12'o2000, 7'o033, 12'o0000, 0, 12'o0000, 12'o0000, 12'o0000);
        tbl[9] = mk(1, 0, 0, 1, 12'o7600, 7'o177, 12'o0000, 0, 12'o0000, 12'o0000, 12'o7777);

        RESET_N = 0; idle_inputs(); MP = 0; IR = '0; PCLATCHED = '0; MEM_RDATA = '0;
        repeat (2) @(negedge CLK);
        chk("rst_ea", EA, 12'd0);
        chk("rst_addr", MEM_ADDR, 12'd0);
        chk("rst_wdata", MEM_WDATA, 12'd0);
        chk("rst_flags", {8'b0, MEM_RD, MEM_WR, EA_VALID, BUSY}, 12'd0);
        RESET_N = 1;
        @(negedge CLK);

        for (int i = 0; i < 10; i++) run(tbl[i]);

        // START pulsed during a PPIND sequence (in DEFER_RD and in DONE) is ignored
        PPIND = 1; MP = 0; IR = 7'o014; START = 1;
        @(negedge CLK);
        PPIND = 0; DIR = 1; IR = 7'o055; START = 1;
        chk("busy_start_rd", {10'b0, MEM_RD, MEM_WR}, 12'd2);
        @(negedge CLK);
        START = 0; DIR = 0;
        chk("busy_start_addr", MEM_ADDR, 12'o0014);
        chk("busy_start_rd2", {10'b0, MEM_RD, MEM_WR}, 12'd2);
        MEM_ACK = 1; MEM_RDATA = 12'o0100;
        @(negedge CLK);
        chk("busy_start_wdata", MEM_WDATA, 12'o0101);
        chk("busy_start_wr", {10'b0, MEM_RD, MEM_WR}, 12'd1);
        @(negedge CLK);
        MEM_ACK = 0;
        chk("busy_start_valid", {11'b0, EA_VALID}, 12'd1);
        chk("busy_start_ea", EA, 12'o0101);
        DIR = 1; IR = 7'o055; START = 1;
        @(negedge CLK);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("busy_start_single_valid", {11'b0, EA_VALID}, 12'd0);
            chk("busy_start_idle", {11'b0, BUSY}, 12'd0);
            @(negedge CLK);
        end
        chk("busy_start_ea_hold", EA, 12'o0101);

        // Asynchronous reset while AUTO_WR waits for MEM_ACK
        PPIND = 1; MP = 0; IR = 7'o011; START = 1;
        @(negedge CLK);
        idle_inputs();
        MEM_ACK = 1; MEM_RDATA = 12'o0200;
        @(negedge CLK);
        MEM_ACK = 0;
        chk("rstmid_wr", {10'b0, MEM_RD, MEM_WR}, 12'd1);
        @(negedge CLK);
        #2 RESET_N = 0;
        #1;
        chk("rstmid_wr_drop", {10'b0, MEM_RD, MEM_WR}, 12'd0);
        chk("rstmid_busy", {11'b0, BUSY}, 12'd0);
        chk("rstmid_ea", EA, 12'd0);
        last_ea = '0;
        @(negedge CLK);
        MEM_ACK = 1;
        @(negedge CLK);
        MEM_ACK = 0;
        RESET_N = 1;
        @(negedge CLK);
        chk("rstmid_stay_idle", {10'b0, MEM_WR, BUSY}, 12'd0);
        run(mk(1, 0, 0, 1, 12'o4200, 7'o045, 12'o0000, 0, 12'o0000, 12'o0000, 12'o4245));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
